axil_arbiter: RTL
=================

AXIL_ARBITER -- requirements
Module: axil_arbiter

Interface
REQ-001 SHALL have parameter AW, default 4, AXI4-Lite address width.
REQ-002 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-003 SHALL have reset rstn, synchronous, active-low; clock clk.
REQ-004 SHALL have port req_vld  in  2  per-requester command valid; bit i = requester i.
REQ-005 SHALL have port req_rdy  out  2  per-requester command accept pulse.
REQ-006 SHALL have port req_we  in  2  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  2*AW  requester i address in bits [i*AW +: AW].
REQ-008 SHALL have port req_wdata  in  16  requester i write byte in bits [i*8 +: 8].
REQ-009 SHALL have port rsp_vld  out  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port rsp_data  out  8  read byte, valid with rsp_vld.
REQ-011 SHALL have port rsp_err  out  1  resp[1] of the completing transaction, valid with rsp_vld.
REQ-012 SHALL have ports m_araddr out AW; m_arvalid out 1; m_arready in 1: AXI read address channel.
REQ-013 SHALL have ports m_rdata in 32; m_rresp in 2; m_rvalid in 1; m_rready out 1: AXI read data channel.
REQ-014 SHALL have ports m_awaddr out AW; m_awvalid out 1; m_awready in 1: AXI write address channel.
REQ-015 SHALL have ports m_wdata out 32; m_wstrb out 4; m_wvalid out 1; m_wready in 1: AXI write data channel.
REQ-016 SHALL have ports m_bresp in 2; m_bvalid in 1; m_bready out 1: AXI write response channel.

Function
REQ-017 SHALL implement states IDLE, RADDR, RDATA, WREQ, WRESP, with exactly one AXI transaction outstanding at a time.
REQ-018 In IDLE with any req_vld bit set: SHALL select the winner, pulse req_rdy[winner] for one cycle, latch we/addr/wdata, then go to RADDR (read) or WREQ (write).
REQ-019 Round-robin arbitration: when both requesters request, SHALL grant the one not granted last; a lone requester always wins.
REQ-020 RADDR: SHALL hold m_arvalid=1 until m_arready is seen, then go to RDATA with m_rready=1.
REQ-021 RDATA: on m_rvalid&m_rready SHALL drop m_rready, pulse rsp_vld[winner] next cycle with rsp_data=m_rdata[7:0] and rsp_err=m_rresp[1], then return to IDLE.
REQ-022 WREQ: SHALL raise m_awvalid and m_wvalid together and drop each on its own handshake, in either order or in the same cycle; once both are low, SHALL raise m_bready and go to WRESP.
REQ-023 WRESP: on m_bvalid&m_bready SHALL drop m_bready and pulse rsp_vld[winner] with rsp_err=m_bresp[1] and rsp_data=0, then return to IDLE.
REQ-024 m_awaddr SHALL equal m_araddr, which equals the latched address; m_wdata SHALL be {24'b0, latched byte}; m_wstrb SHALL be constant 4'b0001.
REQ-025 Turnaround: a new grant SHALL NOT occur in the cycle rsp_vld pulses; the minimum gap is one IDLE cycle.
REQ-026 Requesters SHALL hold req_vld and their command fields stable until req_rdy; the arbiter SHALL ignore req_vld while not in IDLE.
REQ-027 AXI inputs SHALL be ignored outside the state that consumes them; a stray m_rvalid or m_bvalid SHALL NOT produce rsp_vld.

Reset
REQ-028 On rstn=0: state=IDLE; req_rdy, rsp_vld, rsp_err, rsp_data, m_arvalid, m_rready, m_awvalid, m_wvalid and m_bready SHALL all be 0; last-grant=1, so requester 0 wins the first contention.
REQ-029 Reset mid-transaction SHALL abandon that transaction silently, with no rsp_vld.

Configuration
REQ-030 With macro AXIL_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win contention and the last-grant register SHALL be removed; undefined, round-robin per REQ-019 applies.

Verification
REQ-031 Single read: req_vld=01, we=0, addr=8, slave returns rdata=0x5A, rresp=0 -> m_araddr=8; rsp_vld=01, rsp_data=0x5A, rsp_err=0.
REQ-032 Write with awready 3 cycles before wready: req1 we=1, addr=4, wdata=0x41 -> m_wdata=0x00000041, m_wstrb=0001, bready only after both valids drop; rsp_vld=10.
REQ-033 Contention: req_vld=11 held for 4 transactions -> grant order 0,1,0,1 (round-robin); with AXIL_ARB_FIXED_PRIO_EN -> order 0,0,0,0.
REQ-034 Error: bresp=2'b10 -> rsp_err=1; rresp=2'b11 -> rsp_err=1.
REQ-035 rstn=0 asserted while in RDATA -> all valid/ready outputs 0 next cycle, no rsp_vld; next request is served normally.

Source files
------------

// File: rtl/axil_arbiter.sv
// Two-requester arbiter in front of one AXI4-Lite master port, one transaction outstanding.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module axil_arbiter #(
  parameter int unsigned AW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  // requester side
  input  logic [1:0]      req_vld,
  output logic [1:0]      req_rdy,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [15:0]     req_wdata,
  output logic [1:0]      rsp_vld,
  output logic [7:0]      rsp_data,
  output logic            rsp_err,
  // AXI read address / data
  output logic [AW-1:0]   m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready,
  // AXI write address / data / response
  output logic [AW-1:0]   m_awaddr,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWreq,
    StWresp
  } state_e;

  state_e state_q, state_d;

  logic          win_q, win_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [1:0]    req_rdy_q, req_rdy_d;
  logic [1:0]    rsp_vld_q, rsp_vld_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic grant;
  logic grant_idx;

`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic last_q;
`endif

  // Only the low byte and resp[1] are consumed.
  logic unused_bits;
  assign unused_bits = ^{m_rdata[31:8], m_rresp[0], m_bresp[0]};

  // No grant in the cycle a response pulses, which enforces one idle turnaround cycle.
  always_comb begin
    grant = (state_q == StIdle) && (req_vld != 2'b00) && (rsp_vld_q == 2'b00);
`ifdef AXIL_ARB_FIXED_PRIO_EN
    grant_idx = ~req_vld[0];
`else
    if (req_vld == 2'b11) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = req_vld[1];
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = req_we[grant_idx] ? StWreq : StRaddr;
        end
      end
      StRaddr: begin
        if (m_arready) begin
          state_d = StRdata;
        end
      end
      StRdata: begin
        if (m_rvalid) begin
          state_d = StIdle;
        end
      end
      StWreq: begin
        if ((aw_done_q || m_awready) && (w_done_q || m_wready)) begin
          state_d = StWresp;
        end
      end
      StWresp: begin
        if (m_bvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    m_arvalid = (state_q == StRaddr);
    m_rready  = (state_q == StRdata);
    m_awvalid = (state_q == StWreq) && !aw_done_q;
    m_wvalid  = (state_q == StWreq) && !w_done_q;
    m_bready  = (state_q == StWresp);
  end

  // Datapath next-state
  always_comb begin
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    req_rdy_d  = 2'b00;
    rsp_vld_d  = 2'b00;
    rsp_data_d = 8'h00;
    rsp_err_d  = 1'b0;

    if (grant) begin
      win_d                = grant_idx;
      addr_d               = grant_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
      wdata_d              = grant_idx ? req_wdata[15:8] : req_wdata[7:0];
      aw_done_d            = 1'b0;
      w_done_d             = 1'b0;
      req_rdy_d[grant_idx] = 1'b1;
    end

    // Each write channel drops on its own handshake.
    if (state_q == StWreq) begin
      if (m_awready) begin
        aw_done_d = 1'b1;
      end
      if (m_wready) begin
        w_done_d = 1'b1;
      end
    end

    if ((state_q == StRdata) && m_rvalid) begin
      rsp_vld_d[win_q] = 1'b1;
      rsp_data_d       = m_rdata[7:0];
      rsp_err_d        = m_rresp[1];
    end

    if ((state_q == StWresp) && m_bvalid) begin
      rsp_vld_d[win_q] = 1'b1;
      rsp_err_d        = m_bresp[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      req_rdy_q  <= 2'b00;
      rsp_vld_q  <= 2'b00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      req_rdy_q  <= req_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifndef AXIL_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= grant_idx;
    end
  end
`endif

  assign req_rdy  = req_rdy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign m_araddr = addr_q;
  assign m_awaddr = addr_q;
  assign m_wdata  = {24'h000000, wdata_q};
  assign m_wstrb  = 4'b0001;

endmodule
